// File: rtl/decode_buffer_pkg.sv
// Shared constants and instruction helpers for the decode buffer slice.
package decode_buffer_pkg;

    localparam int unsigned INSTR_W = 32;

    typedef logic [INSTR_W-1:0] instr_t;

    localparam instr_t NOP_INSTR = 32'h0000_0013;

    // Low two bits 2'b11 mark a full 32-bit encoding; anything else is compressed.
    function automatic logic is_full_width(input instr_t instr);
        return instr[1:0] == 2'b11;
    endfunction

endpackage

// File: rtl/decode_buffer_if.sv
// Fetch-to-decode handshake bundle; the buffer sits on the slave modport.
interface decode_buffer_if
    import decode_buffer_pkg::*;
#(
    parameter int unsigned XLEN = 32
) ();

    logic            fetch_valid;
    logic [XLEN-1:0] fetch_pc;
    instr_t          fetch_instr;
    logic            fetch_ready;

    logic            dec_ready;
    logic            dec_valid;
    logic [XLEN-1:0] dec_pc;
    instr_t          dec_instr;
    logic [XLEN-1:0] dec_npc;

    modport master (
        output fetch_valid, fetch_pc, fetch_instr, dec_ready,
        input  fetch_ready, dec_valid, dec_pc, dec_instr, dec_npc
    );

    modport slave (
        input  fetch_valid, fetch_pc, fetch_instr, dec_ready,
        output fetch_ready, dec_valid, dec_pc, dec_instr, dec_npc
    );

endinterface

// File: rtl/decode_buffer_mem.sv
// Entry storage: one synchronous write port, one asynchronous read port.
module decode_buffer_mem #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic                     clock,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata = mem[raddr];
    end

endmodule

// File: rtl/decode_buffer.sv
// Small FIFO between fetch and decode with optional empty-buffer bypass.
module decode_buffer
    import decode_buffer_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned XLEN   = 32,
    parameter int unsigned BYPASS = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   clear,
    decode_buffer_if.slave         bus,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        instr_t          instr;
    } entry_t;

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          active;
    logic          empty;
    logic          bypass_en;
    logic          valid_c;
    logic          push;
    logic          pop;
    entry_t        wr_entry;
    entry_t        rd_entry;
    entry_t        head;

    decode_buffer_mem #(
        .DEPTH (DEPTH),
        .WIDTH (XLEN + INSTR_W)
    ) u_mem (
        .clock (clock),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (rd_entry)
    );

    always_comb begin
        active    = reset && !clear;
        empty     = (count == '0);
        bypass_en = (BYPASS != 0) && empty;
        wr_entry  = '{pc: bus.fetch_pc, instr: bus.fetch_instr};

        bus.fetch_ready = active && (count != FULL);
        valid_c         = active && (empty ? (bypass_en && bus.fetch_valid) : 1'b1);

        // A bypassed instruction that decode takes immediately never lands in storage.
        push = bus.fetch_valid && bus.fetch_ready && !(bypass_en && bus.dec_ready);
        pop  = valid_c && bus.dec_ready && !empty;

        head = bypass_en ? wr_entry : rd_entry;
        if (!valid_c) begin
            head = '{pc: '0, instr: NOP_INSTR};
        end

        bus.dec_valid = valid_c;
        bus.dec_pc    = head.pc;
        bus.dec_instr = head.instr;
        bus.dec_npc   = head.pc + (is_full_width(head.instr) ? XLEN'(4) : XLEN'(2));
    end

    always_ff @(posedge clock) begin
        if (!reset || clear) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_decode_buffer.sv
// Randomized and directed checks of decode_buffer against a queue-based model.
module tb_decode_buffer;
    import decode_buffer_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       clear;
    logic [2:0] count;

    int unsigned tests_run    = 0;
    int unsigned tests_failed = 0;

    logic [63:0] q[$];
    logic        m_active;
    logic        m_valid;
    logic        m_fready;
    int unsigned m_n;

    decode_buffer_if #(.XLEN(32)) bus ();

    decode_buffer #(
        .DEPTH  (DEPTH),
        .XLEN   (32),
        .BYPASS (1)
    ) dut (
        .clock (clock),
        .reset (reset),
        .clear (clear),
        .bus   (bus.slave),
        .count (count)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic clr, input logic fv,
                         input logic [31:0] pc, input logic [31:0] ins, input logic dr);
        reset           = rst;
        clear           = clr;
        bus.fetch_valid = fv;
        bus.fetch_pc    = pc;
        bus.fetch_instr = ins;
        bus.dec_ready   = dr;
    endtask

    // Mid-cycle: derive expected outputs from the queue and compare everything.
    task automatic settle();
        logic [63:0] e;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [31:0] e_npc;
        #4;
        m_active = reset && !clear;
        m_n      = q.size();
        m_fready = m_active && (m_n != DEPTH);
        if (m_n == 0) begin
            m_valid = m_active && bus.fetch_valid;
            e       = {bus.fetch_pc, bus.fetch_instr};
        end else begin
            m_valid = m_active;
            e       = q[0];
        end
        if (!m_valid) e = {32'h0, NOP_INSTR};
        e_pc    = e[63:32];
        e_instr = e[31:0];
        e_npc   = e_pc + ((e_instr[1:0] == 2'b11) ? 32'd4 : 32'd2);
        check_eq("count",       64'(count),           64'(m_n));
        check_eq("fetch_ready", 64'(bus.fetch_ready), 64'(m_fready));
        check_eq("dec_valid",   64'(bus.dec_valid),   64'(m_valid));
        check_eq("dec_pc",      64'(bus.dec_pc),      64'(e_pc));
        check_eq("dec_instr",   64'(bus.dec_instr),   64'(e_instr));
        check_eq("dec_npc",     64'(bus.dec_npc),     64'(e_npc));
    endtask

    task automatic clock_edge();
        @(posedge clock);
        if (!m_active) begin
            q.delete();
        end else if (m_n == 0) begin
            if (bus.fetch_valid && !bus.dec_ready) q.push_back({bus.fetch_pc, bus.fetch_instr});
        end else begin
            if (m_valid && bus.dec_ready) void'(q.pop_front());
            if (bus.fetch_valid && m_fready) q.push_back({bus.fetch_pc, bus.fetch_instr});
        end
        #1;
    endtask

    task automatic step(input logic rst, input logic clr, input logic fv,
                        input logic [31:0] pc, input logic [31:0] ins, input logic dr);
        drive(rst, clr, fv, pc, ins, dr);
        settle();
        clock_edge();
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 32'h0, NOP_INSTR, 1'b0);
        @(posedge clock);
        #1;
        step(1'b0, 1'b0, 1'b1, 32'h80, NOP_INSTR, 1'b1);

        drive(1'b0, 1'b0, 1'b1, 32'h84, NOP_INSTR, 1'b0);
        settle();
        check_eq("rst_fetch_ready", 64'(bus.fetch_ready), 64'd0);
        check_eq("rst_dec_valid",   64'(bus.dec_valid),   64'd0);
        clock_edge();

        // Release and fill with decode stalled.
        drive(1'b1, 1'b0, 1'b1, 32'h100, 32'h0000_0013, 1'b0);
        settle();
        check_eq("rel_count",       64'(count),           64'd0);
        check_eq("rel_fetch_ready", 64'(bus.fetch_ready), 64'd1);
        check_eq("rel_dec_valid",   64'(bus.dec_valid),   64'd1);
        clock_edge();
        for (int i = 1; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b1, 32'h100 + 32'(4 * i), 32'h0000_0013 + 32'(i << 8), 1'b0);
        end
        drive(1'b1, 1'b0, 1'b1, 32'h110, NOP_INSTR, 1'b0);
        settle();
        check_eq("fill_count",       64'(count),           64'd4);
        check_eq("fill_fetch_ready", 64'(bus.fetch_ready), 64'd0);
        check_eq("fill_dec_pc",      64'(bus.dec_pc),      64'h100);
        clock_edge();

        // Clear while full and pushing.
        drive(1'b1, 1'b1, 1'b1, 32'h500, NOP_INSTR, 1'b1);
        settle();
        check_eq("clr_dec_valid",   64'(bus.dec_valid),   64'd0);
        check_eq("clr_fetch_ready", 64'(bus.fetch_ready), 64'd0);
        clock_edge();
        drive(1'b1, 1'b0, 1'b0, 32'h504, 32'hFFFF_FFFF, 1'b0);
        settle();
        check_eq("clr_count",     64'(count),         64'd0);
        check_eq("clr_valid_q",   64'(bus.dec_valid), 64'd0);
        check_eq("clr_dec_instr", 64'(bus.dec_instr), 64'h13);
        clock_edge();

        // Bypass on empty buffer.
        drive(1'b1, 1'b0, 1'b1, 32'h200, 32'h0000_0013, 1'b1);
        settle();
        check_eq("byp_dec_valid", 64'(bus.dec_valid), 64'd1);
        check_eq("byp_dec_npc",   64'(bus.dec_npc),   64'h204);
        clock_edge();
        drive(1'b1, 1'b0, 1'b0, 32'h0, NOP_INSTR, 1'b1);
        settle();
        check_eq("byp_count", 64'(count), 64'd0);
        clock_edge();

        // Compressed instruction popped from storage.
        step(1'b1, 1'b0, 1'b1, 32'h300, 32'h0000_4501, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, NOP_INSTR, 1'b1);
        settle();
        check_eq("cmp_dec_pc",  64'(bus.dec_pc),  64'h300);
        check_eq("cmp_dec_npc", 64'(bus.dec_npc), 64'h302);
        clock_edge();

        // Pointer wrap with one entry resident.
        step(1'b1, 1'b0, 1'b1, 32'h400, 32'h0000_0003, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            drive(1'b1, 1'b0, 1'b1, 32'h400 + 32'(4 * i), 32'h0000_0003 + 32'(i << 12), 1'b1);
            settle();
            check_eq("wrap_count",  64'(count),      64'd1);
            check_eq("wrap_dec_pc", 64'(bus.dec_pc), 64'(32'h400 + 32'(4 * (i - 1))));
            clock_edge();
        end
        step(1'b1, 1'b0, 1'b0, 32'h0, NOP_INSTR, 1'b1);

        // Reset pulse with three entries held.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b1, 32'h600 + 32'(4 * i), 32'h0000_0013, 1'b0);
        end
        step(1'b0, 1'b0, 1'b0, 32'h0, NOP_INSTR, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h0, NOP_INSTR, 1'b1);
            settle();
            check_eq("rp_count",     64'(count),         64'd0);
            check_eq("rp_dec_valid", 64'(bus.dec_valid), 64'd0);
            clock_edge();
        end

        // Random traffic including occasional clear and reset.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] ins;
            ins = $urandom;
            step(($urandom_range(0, 49) != 0), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 3) != 0), $urandom, ins,
                 ($urandom_range(0, 2) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/decode_buffer.md
DECODE_BUFFER -- requirements
Module: decode_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, buffer entries; power of two, >= 2.
REQ-002 SHALL have parameter XLEN, default 32, PC width.
REQ-003 SHALL have parameter BYPASS, default 1; 1 = empty-buffer combinational pass-through, 0 = minimum one-cycle latency.
REQ-004 SHALL have port clock  input  1  clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port clear  input  1  synchronous flush (trap, mret, fence, taken jump).
REQ-007 SHALL have port fetch_valid  input  1  fetch offers an instruction.
REQ-008 SHALL have port fetch_pc  input  XLEN  PC of offered instruction.
REQ-009 SHALL have port fetch_instr  input  32  offered instruction word.
REQ-010 SHALL have port fetch_ready  output  1  buffer accepts this cycle.
REQ-011 SHALL have port dec_ready  input  1  decode consumes this cycle (not stalled).
REQ-012 SHALL have port dec_valid  output  1  head entry presented.
REQ-013 SHALL have port dec_pc  output  XLEN  head PC.
REQ-014 SHALL have port dec_instr  output  32  head instruction.
REQ-015 SHALL have port dec_npc  output  XLEN  head next PC.
REQ-016 SHALL have port count  output  $clog2(DEPTH)+1  occupancy.

Function
REQ-017 SHALL push when fetch_valid && fetch_ready and not bypassed, writing {pc, instr} at write pointer.
REQ-018 SHALL pop when dec_valid && dec_ready, advancing read pointer.
REQ-019 SHALL wrap both pointers modulo DEPTH.
REQ-020 SHALL drive fetch_ready = (count != DEPTH) && !clear; no dependence on dec_ready.
REQ-021 SHALL update count +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-022 SHALL, when count == 0 and BYPASS == 1, drive dec_valid = fetch_valid with fetch_pc/fetch_instr combinationally; if dec_ready is also high, no entry is written.
REQ-023 SHALL, when count == 0 and BYPASS == 0, drive dec_valid = 0; a pushed entry is visible the next cycle.
REQ-024 SHALL, when dec_valid == 0, drive dec_pc = 0, dec_instr = nop_instr (0x00000013), dec_npc = 4.
REQ-025 SHALL compute dec_npc = dec_pc + 4 if dec_instr[1:0] == 2'b11, else dec_pc + 2, truncated to XLEN.
REQ-026 SHALL, on clear, force dec_valid = 0 and fetch_ready = 0 that cycle, discard any push/pop, and set count and both pointers to 0 at the next edge.
REQ-027 SHALL hold head outputs stable while dec_valid && !dec_ready.

Reset
REQ-028 SHALL, while reset == 0, set count, read and write pointers to 0 at the edge; drive fetch_ready = 0, dec_valid = 0 combinationally.
REQ-029 SHALL, in the first cycle after reset release, drive count 0, fetch_ready 1, dec_valid = BYPASS ? fetch_valid : 0.
REQ-030 SHALL treat reset mid-operation identically to clear; entry storage need not be reset.

Structure
REQ-031 SHALL take nop_instr from the constants package.
REQ-032 SHALL define the entry typedef (pc, instr) and the port structs in the wires package.
REQ-033 SHALL place storage in one natural sub-module, decode_buffer_mem (DEPTH x (XLEN+32), one write port, one asynchronous read port).

Verification
REQ-034 SHALL cover fill: dec_ready = 0, push PCs 0x100, 0x104, 0x108, 0x10C -> count 4, fetch_ready 0, dec_pc 0x100.
REQ-035 SHALL cover bypass: empty, BYPASS 1, fetch 0x200/0x00000013, dec_ready 1 -> dec_valid 1 same cycle, dec_npc 0x204, count stays 0.
REQ-036 SHALL cover compressed: pop instr 0x4501 at PC 0x300 -> dec_npc 0x302.
REQ-037 SHALL cover clear while full and pushing -> next cycle count 0, dec_valid 0, dec_instr 0x00000013.
REQ-038 SHALL cover wrap: 10 push/pop pairs with DEPTH 4 -> order preserved, count constant at 1.
REQ-039 SHALL cover reset pulse with count 3 -> count 0, dec_valid 0, old entries never reappear.
